text_cursor_writer: RTL and testbench

TEXT_CURSOR_WRITER -- requirements
Module: text_cursor_writer

---
 rtl/text_cursor_writer.sv | 169 ++++++++++++++++
 tb/tb_text_cursor_writer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/text_cursor_writer.sv
`default_nettype none
// ============================================================================
//  Module      : text_cursor_writer
//  Description : Converts a byte stream into character-plane writes on a
//                16x32 text grid. Printables are written at the cursor and
//                advance it. CR, LF and BS move the cursor. FF launches a
//                full-screen clear sweep that runs for 512 cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module text_cursor_writer #(
    parameter logic [7:0] CLEAR_CHAR     = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_char,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       wr_en,
    output logic [7:0] wr_character_id,
    output logic [3:0] wr_row,
    output logic [4:0] wr_column,
    output logic [3:0] cursor_row,
    output logic [4:0] cursor_column,
    output logic       busy
);

    localparam logic [7:0] C_CHAR_BS = 8'h08;
    localparam logic [7:0] C_CHAR_LF = 8'h0A;
    localparam logic [7:0] C_CHAR_FF = 8'h0C;
    localparam logic [7:0] C_CHAR_CR = 8'h0D;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t     state_q;
    logic       init_q;        // low only until the first edge after reset release
    logic [8:0] sweep_q;       // next grid cell the clear sweep will write
    logic [3:0] cur_row_q;
    logic [4:0] cur_col_q;
    logic       wr_en_q;
    logic [7:0] wr_id_q;
    logic [3:0] wr_row_q;
    logic [4:0] wr_col_q;
    logic       in_ready_q;
    logic       busy_q;

    logic       w_accept;
    logic       w_printable;
    logic       w_enter_clear;
    logic [4:0] w_col_inc;
    logic [3:0] w_row_inc;
    logic [4:0] w_col_dec;
    logic [3:0] w_row_dec;

    // in_ready_q is only ever high in IDLE, so it alone qualifies an accept
    assign w_accept      = in_valid & in_ready_q;
    assign w_printable   = (in_char >= 8'h20) && (in_char <= 8'h7E);
    assign w_enter_clear = (!init_q && CLEAR_ON_RESET) ||
                           (init_q && (state_q == ST_IDLE) && w_accept && (in_char == C_CHAR_FF));

    // Cursor arithmetic wraps naturally at the field widths
    assign w_col_inc = cur_col_q + 5'd1;
    assign w_row_inc = cur_row_q + 4'd1;
    assign w_col_dec = cur_col_q - 5'd1;
    assign w_row_dec = cur_row_q - 4'd1;

    // Main FSM: byte decoding, cursor tracking, clear sweep and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            init_q     <= 1'b0;
            sweep_q    <= 9'd0;
            cur_row_q  <= 4'd0;
            cur_col_q  <= 5'd0;
            wr_en_q    <= 1'b0;
            wr_id_q    <= 8'd0;
            wr_row_q   <= 4'd0;
            wr_col_q   <= 5'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            init_q  <= 1'b1;
            wr_en_q <= 1'b0;
            if (w_enter_clear) begin
                // The entry edge already presents cell (0,0) so the sweep
                // occupies exactly 512 busy cycles
                state_q    <= ST_CLEAR;
                busy_q     <= 1'b1;
                in_ready_q <= 1'b0;
                wr_en_q    <= 1'b1;
                wr_id_q    <= CLEAR_CHAR;
                wr_row_q   <= 4'd0;
                wr_col_q   <= 5'd0;
                sweep_q    <= 9'd1;
            end else if (!init_q) begin
                state_q    <= ST_IDLE;
                in_ready_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_CLEAR: begin
                        if (sweep_q == 9'd0) begin
                            // Counter wrapped: all 512 cells have been written
                            state_q    <= ST_IDLE;
                            busy_q     <= 1'b0;
                            in_ready_q <= 1'b1;
                            cur_row_q  <= 4'd0;
                            cur_col_q  <= 5'd0;
                        end else begin
                            wr_en_q  <= 1'b1;
                            wr_id_q  <= CLEAR_CHAR;
                            wr_row_q <= sweep_q[8:5];
                            wr_col_q <= sweep_q[4:0];
                            sweep_q  <= sweep_q + 9'd1;
                        end
                    end
                    default: begin
                        if (w_accept) begin
                            if (w_printable) begin
                                wr_en_q   <= 1'b1;
                                wr_id_q   <= in_char;
                                wr_row_q  <= cur_row_q;
                                wr_col_q  <= cur_col_q;
                                cur_col_q <= w_col_inc;
                                if (cur_col_q == 5'd31) begin
                                    cur_row_q <= w_row_inc;
                                end
                            end else if (in_char == C_CHAR_CR) begin
                                cur_col_q <= 5'd0;
                            end else if (in_char == C_CHAR_LF) begin
                                cur_col_q <= 5'd0;
                                cur_row_q <= w_row_inc;
                            end else if (in_char == C_CHAR_BS) begin
                                if (cur_col_q != 5'd0) begin
                                    cur_col_q <= w_col_dec;
                                    wr_en_q   <= 1'b1;
                                    wr_id_q   <= CLEAR_CHAR;
                                    wr_row_q  <= cur_row_q;
                                    wr_col_q  <= w_col_dec;
                                end else if (cur_row_q != 4'd0) begin
                                    cur_row_q <= w_row_dec;
                                    cur_col_q <= 5'd31;
                                    wr_en_q   <= 1'b1;
                                    wr_id_q   <= CLEAR_CHAR;
                                    wr_row_q  <= w_row_dec;
                                    wr_col_q  <= 5'd31;
                                end
                            end
                            // Any other byte is consumed without effect
                        end
                    end
                endcase
            end
        end
    end

    assign in_ready        = in_ready_q;
    assign busy            = busy_q;
    assign wr_en           = wr_en_q;
    assign wr_character_id = wr_id_q;
    assign wr_row          = wr_row_q;
    assign wr_column       = wr_col_q;
    assign cursor_row      = cur_row_q;
    assign cursor_column   = cur_col_q;

endmodule
`default_nettype wire

// File: tb/tb_text_cursor_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_cursor_writer
//  Description : Directed self-checking bench for text_cursor_writer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_text_cursor_writer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_char;
    logic       in_valid;
    logic       in_ready;
    logic       wr_en;
    logic [7:0] wr_character_id;
    logic [3:0] wr_row;
    logic [4:0] wr_column;
    logic [3:0] cursor_row;
    logic [4:0] cursor_column;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    text_cursor_writer #(
        .CLEAR_CHAR     (8'h20),
        .CLEAR_ON_RESET (1'b1)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_char         (in_char),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .wr_en           (wr_en),
        .wr_character_id (wr_character_id),
        .wr_row          (wr_row),
        .wr_column       (wr_column),
        .cursor_row      (cursor_row),
        .cursor_column   (cursor_column),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a byte, wait (bounded) for in_ready, let one edge accept it
    task automatic send(input logic [7:0] b);
        int waited;
        waited   = 0;
        in_char  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 2000) begin
            tick();
            waited++;
        end
        if (!in_ready) check("send_ready_timeout", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Called with the first sweep write visible; checks all 512 cells then the return to IDLE
    task automatic run_sweep(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            if (wr_en !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 ||
                wr_character_id !== 8'h20 || {wr_row, wr_column} !== i[8:0]) begin
                bad++;
            end
            if (i < 511) tick();
        end
        check({tag, "_sweep_bad_cells"}, bad, 0);
        tick();
        check({tag, "_end_busy_ready_wren"}, {29'd0, busy, in_ready, wr_en}, 32'b010);
        check({tag, "_end_cursor"}, {23'd0, cursor_row, cursor_column}, 32'd0);
    endtask

    task automatic goto_pos(input logic [3:0] r, input logic [4:0] c);
        send(8'h0D);
        for (int k = 0; k < 16 && cursor_row != r; k++) send(8'h0A);
        for (int k = 0; k < 32 && k < int'(c); k++) send(8'h2E);
        check("goto_cursor", {23'd0, cursor_row, cursor_column}, {23'd0, r, c});
    endtask

    logic [8:0] pos32;
    logic [8:0] pos33;

    initial begin
        rst_n    = 1'b0;
        in_char  = 8'h00;
        in_valid = 1'b0;
        #12;
        // Reset values held while rst_n is low
        check("rst_wr_en",   {31'd0, wr_en}, 32'd0);
        check("rst_wr_id",   {24'd0, wr_character_id}, 32'd0);
        check("rst_wr_pos",  {23'd0, wr_row, wr_column}, 32'd0);
        check("rst_cursor",  {23'd0, cursor_row, cursor_column}, 32'd0);
        check("rst_ready",   {31'd0, in_ready}, 32'd0);
        check("rst_busy",    {31'd0, busy}, 32'd0);

        // Power-on clear
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        run_sweep("por");

        // "AB" back-to-back
        check("ab_ready", {31'd0, in_ready}, 32'd1);
        in_char  = 8'h41;
        in_valid = 1'b1;
        tick();
        check("ab_A_write", {15'd0, wr_en, wr_character_id, wr_row, wr_column}, {15'd0, 1'b1, 8'h41, 4'd0, 5'd0});
        in_char = 8'h42;
        tick();
        check("ab_B_write", {15'd0, wr_en, wr_character_id, wr_row, wr_column}, {15'd0, 1'b1, 8'h42, 4'd0, 5'd1});
        in_valid = 1'b0;
        check("ab_cursor", {23'd0, cursor_row, cursor_column}, {23'd0, 4'd0, 5'd2});

        // 33 printables from (0,0)
        goto_pos(4'd0, 5'd0);
        pos32 = '0;
        pos33 = '0;
        for (int k = 1; k <= 33; k++) begin
            send(8'h61);
            if (k == 32) pos32 = {wr_row, wr_column};
            if (k == 33) pos33 = {wr_row, wr_column};
        end
        check("p33_write32", {23'd0, pos32}, {23'd0, 4'd0, 5'd31});
        check("p33_write33", {23'd0, pos33}, {23'd0, 4'd1, 5'd0});
        check("p33_cursor", {23'd0, cursor_row, cursor_column}, {23'd0, 4'd1, 5'd1});

        // Printable at (15,31) wraps to (0,0)
        goto_pos(4'd15, 5'd31);
        send(8'h5A);
        check("wrap_write", {15'd0, wr_en, wr_character_id, wr_row, wr_column}, {15'd0, 1'b1, 8'h5A, 4'd15, 5'd31});
        check("wrap_cursor", {23'd0, cursor_row, cursor_column}, 32'd0);

        // BS at (0,0) does nothing
        send(8'h08);
        check("bs00_wr_en", {31'd0, wr_en}, 32'd0);
        check("bs00_cursor", {23'd0, cursor_row, cursor_column}, 32'd0);

        // Dropped bytes, then BS across a row boundary
        goto_pos(4'd3, 5'd0);
        send(8'h7F);
        check("drop7f_wr_en", {31'd0, wr_en}, 32'd0);
        check("drop7f_cursor", {23'd0, cursor_row, cursor_column}, {23'd0, 4'd3, 5'd0});
        send(8'h01);
        check("drop01_cursor", {23'd0, cursor_row, cursor_column}, {23'd0, 4'd3, 5'd0});
        send(8'h08);
        check("bs30_write", {15'd0, wr_en, wr_character_id, wr_row, wr_column}, {15'd0, 1'b1, 8'h20, 4'd2, 5'd31});
        check("bs30_cursor", {23'd0, cursor_row, cursor_column}, {23'd0, 4'd2, 5'd31});
        send(8'h08);
        check("bs231_write", {15'd0, wr_en, wr_character_id, wr_row, wr_column}, {15'd0, 1'b1, 8'h20, 4'd2, 5'd30});
        check("bs231_cursor", {23'd0, cursor_row, cursor_column}, {23'd0, 4'd2, 5'd30});

        // CR at (5,7)
        goto_pos(4'd5, 5'd7);
        send(8'h0D);
        check("cr_wr_en", {31'd0, wr_en}, 32'd0);
        check("cr_cursor", {23'd0, cursor_row, cursor_column}, {23'd0, 4'd5, 5'd0});

        // LF at (15,4)
        goto_pos(4'd15, 5'd4);
        send(8'h0A);
        check("lf_wr_en", {31'd0, wr_en}, 32'd0);
        check("lf_cursor", {23'd0, cursor_row, cursor_column}, 32'd0);

        // FF with 0x5A held during the sweep
        in_char  = 8'h0C;
        in_valid = 1'b1;
        tick();
        in_char = 8'h5A;
        run_sweep("ff");
        tick();
        in_valid = 1'b0;
        check("ff_held_write", {15'd0, wr_en, wr_character_id, wr_row, wr_column}, {15'd0, 1'b1, 8'h5A, 4'd0, 5'd0});
        check("ff_held_cursor", {23'd0, cursor_row, cursor_column}, {23'd0, 4'd0, 5'd1});

        // Reset asserted at sweep cycle 100
        in_char  = 8'h0C;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check("mid_sweep_pos", {15'd0, wr_en, busy, wr_row, wr_column}, {15'd0, 1'b1, 1'b1, 4'd3, 5'd4});
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("mid_rst_outs", {5'd0, wr_character_id, wr_row, wr_column, cursor_row, cursor_column},
              32'd0);
        check("mid_rst_ready_busy", {30'd0, in_ready, busy}, 32'd0);
        tick();
        tick();
        check("mid_rst_hold_wr_en", {31'd0, wr_en}, 32'd0);
        rst_n = 1'b1;
        tick();
        run_sweep("rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
